array_entry_loader: RTL

- Downstream consumer of the button debouncer's single-cycle press pulses.
- Turns load, start and clear presses plus the slide-switch value into writes to the sorter's array memory.
- Issues a start handshake to the insertion-sort engine and tracks its progress.
- Sits between the debouncers/switches and the sort core; all outputs are registered.

---
 rtl/array_entry_loader_if.sv | 30 +++
 rtl/array_entry_loader.sv | 122 ++++++++++++
 2 files changed

// File: rtl/array_entry_loader_if.sv
// Bundle between the button/switch front end and the array loader:
// debounced pulses and switch value in, memory writes and sort handshake out.
interface array_entry_loader_if #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 3
);
  logic              load_pulse;
  logic              start_pulse;
  logic              clear_pulse;
  logic [DATA_W-1:0] sw_value;
  logic              sort_done;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [IDX_W:0]    elem_count;
  logic              full;
  logic              sort_start;
  logic [IDX_W:0]    sort_len;
  logic [1:0]        state;

  modport master (
    output load_pulse, start_pulse, clear_pulse, sw_value, sort_done,
    input  wr_en, wr_addr, wr_data, elem_count, full, sort_start, sort_len, state
  );

  modport slave (
    input  load_pulse, start_pulse, clear_pulse, sw_value, sort_done,
    output wr_en, wr_addr, wr_data, elem_count, full, sort_start, sort_len, state
  );
endinterface

// File: rtl/array_entry_loader.sv
// Collects switch values into the sorter's array memory on load presses and
// hands the loaded length to the insertion-sort engine on a start press.
module array_entry_loader #(
  parameter int NUM_ELEMS = 8,
  parameter int DATA_W    = 4,
  parameter int IDX_W     = 3
) (
  input  logic                 clk_100mhz,
  input  logic                 rst,
  array_entry_loader_if.slave  bus
);

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_START   = 2'd1,
    S_SORTING = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  localparam logic [IDX_W:0] C_FULL_COUNT = (IDX_W+1)'(NUM_ELEMS);

  state_t            r_state;
  state_t            w_state_next;

  logic              r_wr_en;
  logic [IDX_W-1:0]  r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic [IDX_W:0]    r_count;
  logic              r_full;
  logic              r_sort_start;
  logic [IDX_W:0]    r_sort_len;

  logic              w_load_accept;
  logic              w_count_clear;
  logic              w_wr_en_next;
  logic [IDX_W-1:0]  w_wr_addr_next;
  logic [DATA_W-1:0] w_wr_data_next;
  logic [IDX_W:0]    w_count_next;
  logic              w_full_next;
  logic              w_sort_start_next;
  logic [IDX_W:0]    w_sort_len_next;

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_state <= S_COLLECT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_COLLECT: begin
        if (!bus.clear_pulse && bus.start_pulse && (r_count != '0))
          w_state_next = S_START;
      end
      S_START:   w_state_next = S_SORTING;
      S_SORTING: begin
        if (bus.sort_done)
          w_state_next = S_DONE;
      end
      S_DONE: begin
        if (bus.clear_pulse)
          w_state_next = S_COLLECT;
        else if (bus.start_pulse)
          w_state_next = S_START;
      end
      default:   w_state_next = S_COLLECT;
    endcase
  end

  // A load is dropped whenever a higher-priority press shares its cycle.
  always_comb begin
    w_load_accept     = (r_state == S_COLLECT) && bus.load_pulse &&
                        !bus.clear_pulse && !bus.start_pulse && !r_full;
    w_count_clear     = bus.clear_pulse &&
                        ((r_state == S_COLLECT) || (r_state == S_DONE));
    w_wr_en_next      = w_load_accept;
    w_wr_addr_next    = w_load_accept ? r_count[IDX_W-1:0] : r_wr_addr;
    w_wr_data_next    = w_load_accept ? bus.sw_value : r_wr_data;
    w_count_next      = r_count;
    if (w_count_clear)
      w_count_next = '0;
    else if (w_load_accept)
      w_count_next = r_count + 1'b1;
    w_full_next       = (w_count_next == C_FULL_COUNT);
    w_sort_start_next = (w_state_next == S_START);
    w_sort_len_next   = ((r_state == S_COLLECT) && (w_state_next == S_START)) ?
                        r_count : r_sort_len;
  end

  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_sort_start <= 1'b0;
      r_sort_len   <= '0;
    end else begin
      r_wr_en      <= w_wr_en_next;
      r_wr_addr    <= w_wr_addr_next;
      r_wr_data    <= w_wr_data_next;
      r_count      <= w_count_next;
      r_full       <= w_full_next;
      r_sort_start <= w_sort_start_next;
      r_sort_len   <= w_sort_len_next;
    end
  end

  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.elem_count = r_count;
  assign bus.full       = r_full;
  assign bus.sort_start = r_sort_start;
  assign bus.sort_len   = r_sort_len;
  assign bus.state      = r_state;

endmodule
